// File: rtl/pleiads_nvram_upload_pkg.sv
// Shared types and constants for the Pleiads NVRAM upload path.
// The index and fill byte are also referenced by the emu CONF_STR logic.
package pleiads_upload_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    SERVE,
    FETCH,
    RELEASE
  } upl_state_t;

  localparam logic [7:0] UPL_INDEX_NVRAM = 8'h04;
  localparam logic [7:0] FILL_BYTE_DEF   = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pleiads_nvram_upload_if.sv
// hps_io ioctl upload bus: session/index/strobe/address towards the core, byte and wait back.
interface pleiads_nvram_upload_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/pleiads_upload_rdpipe.sv
// Tracks an outstanding score-RAM read: capture_en pulses RAM_LATENCY cycles after ram_rd.
// Cleared by reset or when the session abandons the fetch.
module pleiads_upload_rdpipe #(
  parameter int RAM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic ram_rd,
  output logic capture_en
);

  logic [RAM_LATENCY-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | RAM_LATENCY'(ram_rd);
    end
  end

  assign capture_en = pipe[RAM_LATENCY-1];

endmodule

// File: rtl/pleiads_nvram_upload.sv
// Serves MiSTer ioctl upload reads from the score-RAM B-port while the game CPU is paused.
// One read in flight plus a one-deep pending strobe; extra strobes set the sticky overrun flag.
module pleiads_nvram_upload
  import pleiads_upload_pkg::*;
#(
  parameter logic [7:0] UPL_INDEX    = UPL_INDEX_NVRAM,
  parameter int         RAM_AW       = 10,
  parameter int         RAM_LATENCY  = 2,
  parameter int         PAUSE_WAIT   = 16,
  parameter int         RELEASE_WAIT = 8,
  parameter logic [7:0] FILL_BYTE    = FILL_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pleiads_nvram_upload_if.slave ioctl,
  output logic                  cpu_pause,
  input  logic                  cpu_pause_ack,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_dout,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_MAX = max2(PAUSE_WAIT, RELEASE_WAIT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  upl_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              pend_vld;
  logic [24:0]       pend_addr;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [7:0]        din_q;
  logic              overrun_q;

  logic        sel;
  logic        active;
  logic        abandon;
  logic        issue;
  logic        issue_in;
  logic [24:0] issue_addr;
  logic        consume;
  logic        strobe_store;
  logic        capture_en;

  assign sel     = ioctl.ioctl_upload && (ioctl.ioctl_index == UPL_INDEX);
  assign active  = (state == PAUSE) || (state == SERVE) || (state == FETCH);
  assign abandon = active && !sel;

  // A pending strobe always wins over a fresh one; the fresh one then takes the freed slot.
  always_comb begin
    issue        = (state == SERVE) && sel && (pend_vld || ioctl.ioctl_rd);
    issue_addr   = pend_vld ? pend_addr : ioctl.ioctl_addr;
    issue_in     = issue && (issue_addr[24:RAM_AW] == '0);
    consume      = issue && pend_vld;
    strobe_store = sel && ioctl.ioctl_rd &&
                   ((state == PAUSE) || (state == FETCH) || ((state == SERVE) && pend_vld));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel) state_nxt = PAUSE;
      PAUSE:   if (!sel) state_nxt = RELEASE;
               else if (cpu_pause_ack || cnt == CW'(PAUSE_WAIT - 1)) state_nxt = SERVE;
      SERVE:   if (!sel) state_nxt = RELEASE;
               else if (issue_in) state_nxt = FETCH;
      FETCH:   if (!sel) state_nxt = RELEASE;
               else if (capture_en) state_nxt = SERVE;
      RELEASE: if (sel) state_nxt = PAUSE;
               else if (cnt == CW'(RELEASE_WAIT - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      ram_addr_q <= '0;
      din_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != CW'(CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end

      if (issue_in) begin
        ram_addr_q <= issue_addr[RAM_AW-1:0];
      end

      if (issue && !issue_in) begin
        din_q <= FILL_BYTE;
      end else if ((state == FETCH) && capture_en && sel) begin
        din_q <= ram_dout;
      end

      if ((state == IDLE || state == RELEASE) && sel) begin
        overrun_q <= 1'b0;
      end

      if (!sel || !active) begin
        pend_vld <= 1'b0;
      end else begin
        if (consume) begin
          pend_vld <= 1'b0;
        end
        if (strobe_store) begin
          if (pend_vld && !consume) begin
            overrun_q <= 1'b1;
          end else begin
            pend_vld  <= 1'b1;
            pend_addr <= ioctl.ioctl_addr;
          end
        end
      end
    end
  end

  pleiads_upload_rdpipe #(
    .RAM_LATENCY (RAM_LATENCY)
  ) u_rdpipe (
    .clk        (clk),
    .reset      (reset),
    .flush      (abandon),
    .ram_rd     (issue_in),
    .capture_en (capture_en)
  );

  assign ram_rd           = issue_in;
  assign ram_addr         = issue_in ? issue_addr[RAM_AW-1:0] : ram_addr_q;
  assign busy             = (state != IDLE);
  assign cpu_pause        = busy;
  assign overrun          = overrun_q;
  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = (state == PAUSE) || (state == FETCH) || ((state == SERVE) && pend_vld);

endmodule

// File: tb/tb_pleiads_nvram_upload.sv
// Directed session walk with randomized read addresses, checked against a byte-level reference model.
module tb_pleiads_nvram_upload;
  import pleiads_upload_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int PW  = 16;
  localparam int RW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_pause;
  logic          cpu_pause_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_dout;
  logic          busy;
  logic          overrun;

  int tests = 0;
  int fails = 0;

  pleiads_nvram_upload_if u_if ();

  pleiads_nvram_upload #(
    .UPL_INDEX    (8'h04),
    .RAM_AW       (AW),
    .RAM_LATENCY  (LAT),
    .PAUSE_WAIT   (PW),
    .RELEASE_WAIT (RW),
    .FILL_BYTE    (8'hFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl         (u_if.slave),
    .cpu_pause     (cpu_pause),
    .cpu_pause_ack (cpu_pause_ack),
    .ram_addr      (ram_addr),
    .ram_rd        (ram_rd),
    .ram_dout      (ram_dout),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Score RAM: data = addr[7:0]^5A, valid LAT cycles after the read strobe, zero otherwise.
  logic [7:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= ram_rd ? (ram_addr[7:0] ^ 8'h5A) : 8'h00;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_dout = rpipe[LAT-1];

  function automatic logic in_win(input logic [24:0] a);
    return a < 25'(1 << AW);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return in_win(a) ? (lo ^ 8'h5A) : 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called the cycle after an in-window issue; walks to the first cycle with wait low.
  task automatic wait_din(input logic [7:0] exp, input string tag);
    int n;
    n = 1;
    while (u_if.ioctl_wait === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, LAT + 1);
    chk({tag, "_din"}, u_if.ioctl_din, exp);
  endtask

  task automatic do_read(input logic [24:0] a, input string tag);
    u_if.ioctl_rd   = 1'b1;
    u_if.ioctl_addr = a;
    #1;
    chk({tag, "_ramrd"}, ram_rd, in_win(a));
    if (in_win(a)) chk({tag, "_ramaddr"}, ram_addr, a[AW-1:0]);
    tick();
    u_if.ioctl_rd = 1'b0;
    if (in_win(a)) begin
      wait_din(ref_byte(a), tag);
    end else begin
      chk({tag, "_fill"}, u_if.ioctl_din, ref_byte(a));
      chk({tag, "_fillwait"}, u_if.ioctl_wait, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] a;
    logic [7:0]  last_din;
    int          n;

    reset             = 1'b1;
    cpu_pause_ack     = 1'b0;
    u_if.ioctl_upload = 1'b0;
    u_if.ioctl_index  = 8'h00;
    u_if.ioctl_rd     = 1'b0;
    u_if.ioctl_addr   = '0;
    tick();
    tick();
    chk("rst_din", u_if.ioctl_din, 8'h00);
    chk("rst_wait", u_if.ioctl_wait, 1'b0);
    chk("rst_pause", cpu_pause, 1'b0);
    chk("rst_ramaddr", ram_addr, '0);
    chk("rst_ramrd", ram_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick();

    // Session with no ack: PAUSE_WAIT cycles of wait, no RAM traffic.
    u_if.ioctl_upload = 1'b1;
    u_if.ioctl_index  = 8'h04;
    tick();
    chk("t1_pause", cpu_pause, 1'b1);
    chk("t1_busy", busy, 1'b1);
    for (int c = 1; c <= PW; c++) begin
      chk("t1_wait_hi", u_if.ioctl_wait, 1'b1);
      chk("t1_no_ramrd", ram_rd, 1'b0);
      tick();
    end
    chk("t1_wait_lo", u_if.ioctl_wait, 1'b0);

    do_read(25'h012, "t2");
    chk("t2_value", u_if.ioctl_din, 8'h48);
    do_read(25'h400, "t3");
    do_read(25'h1000400, "t3_hi");
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) a = 25'($urandom) | 25'h400;
      else a = 25'($urandom_range(0, (1 << AW) - 1));
      do_read(a, "rnd");
    end

    // Strobe in the completion cycle is kept and served next, without overrun.
    a = 25'($urandom_range(0, (1 << AW) - 1));
    u_if.ioctl_rd = 1'b1; u_if.ioctl_addr = 25'h0AB;
    tick();
    u_if.ioctl_rd = 1'b0;
    tick();
    u_if.ioctl_rd = 1'b1; u_if.ioctl_addr = a;
    tick();
    u_if.ioctl_rd = 1'b0;
    #1;
    chk("sc_din", u_if.ioctl_din, ref_byte(25'h0AB));
    chk("sc_ramrd", ram_rd, 1'b1);
    chk("sc_ramaddr", ram_addr, a[AW-1:0]);
    chk("sc_overrun", overrun, 1'b0);
    tick();
    wait_din(ref_byte(a), "sc");

    // Two strobes during one fetch: first kept, second lost.
    u_if.ioctl_rd = 1'b1; u_if.ioctl_addr = 25'h030;
    tick();
    u_if.ioctl_addr = 25'h020;
    tick();
    u_if.ioctl_addr = 25'h021;
    tick();
    u_if.ioctl_rd = 1'b0;
    #1;
    chk("t4_din0", u_if.ioctl_din, ref_byte(25'h030));
    chk("t4_ramrd", ram_rd, 1'b1);
    chk("t4_ramaddr", ram_addr, 10'h020);
    chk("t4_overrun", overrun, 1'b1);
    tick();
    wait_din(ref_byte(25'h020), "t4");
    for (int k = 0; k < 4; k++) begin
      chk("t4_no_extra_rd", ram_rd, 1'b0);
      chk("t4_idle_wait", u_if.ioctl_wait, 1'b0);
      tick();
    end
    chk("t4_overrun_sticky", overrun, 1'b1);
    last_din = ref_byte(25'h020);

    // Abort mid-fetch.
    u_if.ioctl_rd = 1'b1; u_if.ioctl_addr = 25'h055;
    tick();
    u_if.ioctl_rd = 1'b0;
    u_if.ioctl_upload = 1'b0;
    tick();
    chk("t5_wait", u_if.ioctl_wait, 1'b0);
    chk("t5_din_kept", u_if.ioctl_din, last_din);
    chk("t5_pause", cpu_pause, 1'b1);
    for (int k = 1; k < RW; k++) begin
      tick();
      chk("t5_pause_held", cpu_pause, 1'b1);
    end
    tick();
    chk("t5_pause_lo", cpu_pause, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_din_final", u_if.ioctl_din, last_din);
    chk("t5_overrun_kept", overrun, 1'b1);

    // New session with ack and a strobe buffered during PAUSE.
    u_if.ioctl_upload = 1'b1;
    tick();
    chk("s2_overrun_clr", overrun, 1'b0);
    chk("s2_pause", cpu_pause, 1'b1);
    a = 25'($urandom_range(0, (1 << AW) - 1));
    u_if.ioctl_rd = 1'b1; u_if.ioctl_addr = a;
    tick();
    u_if.ioctl_rd = 1'b0;
    cpu_pause_ack = 1'b1;
    chk("s2_wait_pause", u_if.ioctl_wait, 1'b1);
    tick();
    cpu_pause_ack = 1'b0;
    #1;
    chk("s2_ramrd", ram_rd, 1'b1);
    chk("s2_ramaddr", ram_addr, a[AW-1:0]);
    tick();
    wait_din(ref_byte(a), "s2");

    // Re-select during RELEASE: pause never drops.
    u_if.ioctl_upload = 1'b0;
    tick();
    chk("rr_pause0", cpu_pause, 1'b1);
    tick();
    chk("rr_pause1", cpu_pause, 1'b1);
    u_if.ioctl_upload = 1'b1;
    tick();
    chk("rr_pause2", cpu_pause, 1'b1);
    n = 0;
    while (u_if.ioctl_wait === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rr_pause_len", n, PW);

    // Reset while serving.
    reset = 1'b1;
    tick();
    chk("t6_din", u_if.ioctl_din, 8'h00);
    chk("t6_wait", u_if.ioctl_wait, 1'b0);
    chk("t6_pause", cpu_pause, 1'b0);
    chk("t6_ramaddr", ram_addr, '0);
    chk("t6_ramrd", ram_rd, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_overrun", overrun, 1'b0);
    u_if.ioctl_upload = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Wrong index is ignored.
    u_if.ioctl_upload = 1'b1;
    u_if.ioctl_index  = 8'h00;
    for (int k = 0; k < 20; k++) begin
      u_if.ioctl_rd   = (k % 3 == 0);
      u_if.ioctl_addr = 25'($urandom_range(0, (1 << AW) - 1));
      tick();
      chk("t6_idx_pause", cpu_pause, 1'b0);
      chk("t6_idx_ramrd", ram_rd, 1'b0);
    end
    u_if.ioctl_rd = 1'b0;
    chk("t6_idx_din", u_if.ioctl_din, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
